mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of byte locations in the backing array (power of two).
REQ-002 SHALL have parameter LATENCY, default 2, wait-state count 0..255 inserted before each acknowledge.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  32  byte address of the request.
REQ-006 SHALL have port data_in  input  8  write data from the initiator.
REQ-007 SHALL have port data_out  output  8  read data to the initiator.
REQ-008 SHALL have port memory_read_en  input  1  read request level.
REQ-009 SHALL have port memory_write_en  input  1  write request level.
REQ-010 SHALL have port memory_ready  output  1  one-cycle completion acknowledge.
REQ-011 SHALL have port memory_error  output  1  qualifies memory_ready; high = request faulted.

Function
REQ-012 SHALL implement states IDLE, WAIT, ACK, HOLD.
REQ-013 IDLE: on an edge with memory_read_en or memory_write_en high, SHALL latch addr, data_in and request type, load wait counter with LATENCY, go to WAIT (LATENCY>0) or ACK (LATENCY=0).
REQ-014 WAIT: SHALL decrement counter each cycle; on edge where counter equals 1, go to ACK.
REQ-015 memory_ready SHALL be high exactly in ACK, i.e. LATENCY+1 cycles after the accepting edge, for exactly one cycle.
REQ-016 Read commit: on the edge entering ACK, SHALL load data_out with array[latched addr]; data_out SHALL hold that value until the next read commit.
REQ-017 Write commit: on the edge entering ACK, SHALL write latched data_in to array[latched addr]; data_out unchanged.
REQ-018 Request inputs SHALL be ignored outside IDLE; changes to addr/data_in after acceptance SHALL have no effect.
REQ-019 ACK SHALL always go to HOLD; HOLD SHALL go to IDLE on the first edge with both enables low, otherwise stay (no re-trigger on a held level).
REQ-020 Both enables high at acceptance: SHALL perform the write only, memory_error high during ACK.
REQ-021 Out of range (latched addr >= DEPTH): read SHALL set data_out to 8'h00, write SHALL not modify the array, memory_error high during ACK.
REQ-022 memory_error SHALL be low whenever memory_ready is low.
REQ-023 Address compare SHALL use full 32 bits; array index SHALL use low log2(DEPTH) bits only when in range (no wrap-around aliasing).
REQ-024 Array contents SHALL NOT be initialised by reset; X-free contents are the bench's responsibility via prior writes.

Reset
REQ-025 While rst_n low: state IDLE, memory_ready 0, memory_error 0, data_out 8'h00, wait counter 0.
REQ-026 Reset asserted in WAIT SHALL abort the request; the pending write SHALL NOT be committed.
REQ-027 After rst_n rises, an enable already high SHALL be accepted on the first rising edge.

Verification
REQ-028 LATENCY=2: write 8'hA5 to 0x30, then read 0x30 -> each memory_ready pulses 1 cycle at 3 cycles after acceptance, data_out=8'hA5, memory_error=0.
REQ-029 LATENCY=0: read 0x30 held high for 5 cycles -> single memory_ready pulse on cycle after acceptance, no second pulse until enable drops and is reasserted.
REQ-030 Read addr 0x00001000 with DEPTH=4096 -> data_out=8'h00, memory_error=1 with ready; write 8'h11 to 0x1000 then read 0x000 -> 0x000 unchanged.
REQ-031 Both enables with data_in=8'h3C at 0x40 -> memory_error=1, data_out unchanged, subsequent read of 0x40 returns 8'h3C.
REQ-032 Write 8'h77 to 0x50 (LATENCY=4), pulse rst_n low during WAIT -> no memory_ready, read 0x50 returns prior value.
REQ-033 Change addr from 0x30 to 0x31 one cycle after acceptance -> access uses 0x30.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide memory responder: accepts one read/write per request level, inserts
// LATENCY wait states, then acknowledges for one cycle with an error qualifier.
module mem_responder #(
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        memory_read_en,
  input  logic        memory_write_en,
  output logic        memory_ready,
  output logic        memory_error
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW       = 8;
  localparam int unsigned DW       = 8;
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [CW-1:0] LAT_W  = CW'(LATENCY);
  localparam bit          ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     lat_addr;
  logic [DW-1:0]   lat_data;
  logic            lat_wr;
  logic            lat_both;

  logic [DW-1:0]   mem [DEPTH];

  logic            accept_c;
  logic            enter_ack_c;
  logic [31:0]     req_addr_c;
  logic [DW-1:0]   req_data_c;
  logic            req_wr_c;
  logic            req_both_c;
  logic            in_range_c;
  logic [AW-1:0]   idx_c;
  logic            commit_wr_c;

  // Request view: live inputs at the accepting edge, latched copy afterwards
  always_comb begin
    accept_c    = 1'b0;
    enter_ack_c = 1'b0;
    req_addr_c  = lat_addr;
    req_data_c  = lat_data;
    req_wr_c    = lat_wr;
    req_both_c  = lat_both;
    in_range_c  = 1'b0;
    idx_c       = '0;
    commit_wr_c = 1'b0;

    accept_c = (state == IDLE) && (memory_read_en || memory_write_en);
    if (state == IDLE) begin
      req_addr_c = addr;
      req_data_c = data_in;
      req_wr_c   = memory_write_en;
      req_both_c = memory_read_en && memory_write_en;
    end
    enter_ack_c = ((state == WAIT) && (cnt == CW'(1))) || (accept_c && ZERO_LAT);
    // Full 32-bit compare so high addresses never alias into the array
    in_range_c  = (req_addr_c < DEPTH_W);
    idx_c       = req_addr_c[AW-1:0];
    commit_wr_c = rst_n && enter_ack_c && req_wr_c && in_range_c;
  end

  // Backing array, deliberately not reset
  always_ff @(posedge clk) begin
    if (commit_wr_c) begin
      mem[idx_c] <= req_data_c;
    end
  end

  // Control FSM with registered acknowledge, error and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_wr       <= 1'b0;
      lat_both     <= 1'b0;
      data_out     <= '0;
      memory_ready <= 1'b0;
      memory_error <= 1'b0;
    end else begin
      memory_ready <= 1'b0;
      memory_error <= 1'b0;

      if (enter_ack_c) begin
        memory_ready <= 1'b1;
        memory_error <= req_both_c || !in_range_c;
        if (!req_wr_c) begin
          data_out <= in_range_c ? mem[idx_c] : '0;
        end
      end

      case (state)
        IDLE: begin
          if (accept_c) begin
            lat_addr <= addr;
            lat_data <= data_in;
            lat_wr   <= memory_write_en;
            lat_both <= memory_read_en && memory_write_en;
            cnt      <= LAT_W;
            state    <= ZERO_LAT ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ACK;
          end
        end
        ACK: begin
          state <= HOLD;
        end
        HOLD: begin
          // Wait for the request level to drop so a held enable never re-triggers
          if (!memory_read_en && !memory_write_en) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with LATENCY 2, 0 and 4
// exercise timing, range/error handling, reset abort and request latching.
module tb_mem_responder;

  localparam int unsigned NI = 3;
  localparam int unsigned LAT [NI] = '{2, 0, 4};

  logic        clk;
  logic        rst_n;
  logic [31:0] addr [NI];
  logic [7:0]  din  [NI];
  logic [7:0]  dout [NI];
  logic        rd   [NI];
  logic        wr   [NI];
  logic        rdy  [NI];
  logic        err  [NI];

  int n_checks;
  int n_fail;

  mem_responder #(.DEPTH(4096), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .data_in(din[0]), .data_out(dout[0]),
    .memory_read_en(rd[0]), .memory_write_en(wr[0]),
    .memory_ready(rdy[0]), .memory_error(err[0])
  );

  mem_responder #(.DEPTH(4096), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .data_in(din[1]), .data_out(dout[1]),
    .memory_read_en(rd[1]), .memory_write_en(wr[1]),
    .memory_ready(rdy[1]), .memory_error(err[1])
  );

  mem_responder #(.DEPTH(4096), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .addr(addr[2]), .data_in(din[2]), .data_out(dout[2]),
    .memory_read_en(rd[2]), .memory_write_en(wr[2]),
    .memory_ready(rdy[2]), .memory_error(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; drives a request, checks the ack timing and payload,
  // optionally keeps the enable for 'hold' extra cycles and moves addr/data
  // one cycle after acceptance.
  task automatic txn(input int k, input string tag, input logic [31:0] a,
                     input logic [7:0] d, input logic r, input logic w,
                     input logic [7:0] exp_dout, input logic exp_err,
                     input int hold, input bit chg);
    int early;
    int extra;
    early = 0;
    extra = 0;
    addr[k] = a;
    din[k]  = d;
    rd[k]   = r;
    wr[k]   = w;
    @(posedge clk);
    for (int i = 1; i <= int'(LAT[k]); i++) begin
      @(negedge clk);
      if (rdy[k]) early++;
      if (chg && i == 1) begin
        addr[k] = a + 32'd1;
        din[k]  = ~d;
      end
    end
    @(negedge clk);
    check($sformatf("%s.early", tag), 32'(early), 32'd0);
    check($sformatf("%s.rdy", tag), 32'(rdy[k]), 32'd1);
    check($sformatf("%s.err", tag), 32'(err[k]), 32'(exp_err));
    check($sformatf("%s.dout", tag), 32'(dout[k]), 32'(exp_dout));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rdy[k] || err[k]) extra++;
    end
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rdy[k] || err[k]) extra++;
    end
    check($sformatf("%s.extra", tag), 32'(extra), 32'd0);
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int k = 0; k < int'(NI); k++) begin
      addr[k] = '0;
      din[k]  = '0;
      rd[k]   = 1'b0;
      wr[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < int'(NI); k++) begin
      check($sformatf("rst%0d.rdy", k), 32'(rdy[k]), 32'd0);
      check($sformatf("rst%0d.err", k), 32'(err[k]), 32'd0);
      check($sformatf("rst%0d.dout", k), 32'(dout[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LATENCY=2: basic write/read, addr latching, range and conflict handling
    txn(0, "wr30",   32'h30,        8'hA5, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    txn(0, "rd30",   32'h30,        8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 0, 1'b0);
    txn(0, "wr31",   32'h31,        8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 0, 1'b0);
    txn(0, "rdchg",  32'h30,        8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 0, 1'b1);
    txn(0, "rdoor",  32'h1000,      8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    txn(0, "wr0",    32'h0,         8'h22, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    txn(0, "wroor",  32'h1000,      8'h11, 1'b0, 1'b1, 8'h00, 1'b1, 0, 1'b0);
    txn(0, "rd0",    32'h0,         8'h00, 1'b1, 1'b0, 8'h22, 1'b0, 0, 1'b0);
    txn(0, "rdhi",   32'h0001_0030, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    txn(0, "wr40",   32'h40,        8'h99, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    txn(0, "rd40",   32'h40,        8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 0, 1'b0);
    txn(0, "both40", 32'h40,        8'h3C, 1'b1, 1'b1, 8'h99, 1'b1, 0, 1'b0);
    txn(0, "rd40b",  32'h40,        8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 0, 1'b0);

    // LATENCY=0: held read level gives one pulse, reassertion gives another
    txn(1, "l0wr",   32'h30, 8'h5C, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    txn(1, "l0hold", 32'h30, 8'h00, 1'b1, 1'b0, 8'h5C, 1'b0, 4, 1'b0);
    txn(1, "l0re",   32'h30, 8'h00, 1'b1, 1'b0, 8'h5C, 1'b0, 0, 1'b0);

    // LATENCY=4: reset during WAIT aborts the pending write
    txn(2, "l4wr", 32'h50, 8'h66, 1'b0, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    addr[2] = 32'h50;
    din[2]  = 8'h77;
    wr[2]   = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.rdy_rst", 32'(rdy[2]), 32'd0);
    cnt = 0;
    @(negedge clk);
    wr[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rdy[2]) cnt++;
    end
    check("abort.noack", 32'(cnt), 32'd0);
    txn(2, "l4rd", 32'h50, 8'h00, 1'b1, 1'b0, 8'h66, 1'b0, 0, 1'b0);

    // Enable already high as reset releases is taken on the first edge
    rst_n   = 1'b0;
    addr[0] = 32'h30;
    rd[0]   = 1'b1;
    cnt     = 0;
    repeat (3) begin
      @(negedge clk);
      if (rdy[0]) cnt++;
    end
    check("rstrel.inrst_rdy", 32'(cnt), 32'd0);
    check("rstrel.inrst_dout", 32'(dout[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rdy[0]) cnt++;
    end
    @(negedge clk);
    check("rstrel.early", 32'(cnt), 32'd0);
    check("rstrel.rdy", 32'(rdy[0]), 32'd1);
    check("rstrel.dout", 32'(dout[0]), 32'hA5);
    rd[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
